// File: rtl/lcd_arb_pkg.sv
// Shared types and default timing constants for the LCD frame arbiter.
package lcd_arb_pkg;

  localparam int DEF_HOLD_CYC  = 100_000;
  localparam int DEF_FRAME_CYC = 8_000_000;
  localparam int IDX_W         = 3;

  localparam logic [127:0] BLANK_LINE = {16{8'h20}};

  typedef enum logic [1:0] {
    WAIT_RDY,
    IDLE,
    ASSERT,
    SETTLE
  } state_t;

  typedef struct packed {
    logic [127:0] line1;
    logic [127:0] line2;
  } lcd_frame_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above ptr, wrapping.
module rr_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [7:0]       req8;
  logic [3:0]       sum;
  logic [IDX_W-1:0] cand;

  // Widen req to 8 bits so a 3-bit candidate index always fits.
  always_comb begin
    req8   = '0;
    req8[N_REQ-1:0] = req;
    idx    = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + 4'(k);
      if (sum >= 4'(N_REQ)) sum = sum - 4'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (!valid && req8[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    for (int i = 0; i < N_REQ; i++) winner[i] = valid && (idx == IDX_W'(i));
  end

endmodule

// File: rtl/lcd_frame_arbiter.sv
// Round-robin arbiter sharing one lcd_controller among N_REQ frame producers.
// Optional LCD_ARB_SKIP_DUP_EN: a grant whose frame matches the displayed one completes at once.
module lcd_frame_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int FRAME_CYC = DEF_FRAME_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*128-1:0] req_line1,
  input  logic [N_REQ*128-1:0] req_line2,
  input  logic                 lcd_ready,
  output logic [127:0]         line1,
  output logic [127:0]         line2,
  output logic                 refresh,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 abort,
  output logic                 busy,
  output logic [2:0]           owner
);

  localparam int CNT_MAX = (HOLD_CYC > FRAME_CYC) ? HOLD_CYC : FRAME_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, owner_nxt;
  lcd_frame_t       frame, frame_nxt, win_frame;
  logic             refresh_nxt, abort_nxt, busy_nxt;
  logic [N_REQ-1:0] gnt_nxt, done_nxt, win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (win_onehot),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  always_comb begin
    win_frame = '{line1: BLANK_LINE, line2: BLANK_LINE};
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        win_frame.line1 = req_line1[i*128 +: 128];
        win_frame.line2 = req_line2[i*128 +: 128];
      end
    end
  end

  // Every output is computed here as a next value and registered below.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    frame_nxt   = frame;
    refresh_nxt = refresh;
    gnt_nxt     = '0;
    done_nxt    = '0;
    abort_nxt   = 1'b0;
    unique case (state)
      WAIT_RDY: begin
        if (lcd_ready) state_nxt = IDLE;
      end
      IDLE: begin
        if (win_valid) begin
          owner_nxt = win_idx;
          ptr_nxt   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          gnt_nxt   = win_onehot;
          frame_nxt = win_frame;
`ifdef LCD_ARB_SKIP_DUP_EN
          if (win_frame == frame) begin
            done_nxt = win_onehot;
          end else begin
            refresh_nxt = 1'b1;
            cnt_nxt     = HOLD_LOAD;
            state_nxt   = ASSERT;
          end
`else
          refresh_nxt = 1'b1;
          cnt_nxt     = HOLD_LOAD;
          state_nxt   = ASSERT;
`endif
        end
      end
      ASSERT: begin
        if (!lcd_ready) begin
          refresh_nxt = 1'b0;
          abort_nxt   = 1'b1;
          state_nxt   = WAIT_RDY;
        end else if (cnt == '0) begin
          refresh_nxt = 1'b0;
          cnt_nxt     = FRAME_LOAD;
          state_nxt   = SETTLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (!lcd_ready) begin
          abort_nxt = 1'b1;
          state_nxt = WAIT_RDY;
        end else if (cnt == '0) begin
          for (int i = 0; i < N_REQ; i++) done_nxt[i] = (owner == IDX_W'(i));
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = WAIT_RDY;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= WAIT_RDY;
      cnt     <= '0;
      ptr     <= '0;
      owner   <= '0;
      frame   <= '{line1: BLANK_LINE, line2: BLANK_LINE};
      refresh <= 1'b0;
      gnt     <= '0;
      done    <= '0;
      abort   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      owner   <= owner_nxt;
      frame   <= frame_nxt;
      refresh <= refresh_nxt;
      gnt     <= gnt_nxt;
      done    <= done_nxt;
      abort   <= abort_nxt;
      busy    <= busy_nxt;
    end
  end

  assign line1 = frame.line1;
  assign line2 = frame.line2;

endmodule
